alu_issue_seq: RTL and testbench

//  Sequencer wrapped around the combinational ripple-carry ALU: accepts one operation at a time
//  on a valid/ready input, drives registered operands/control to the ALU, waits a fixed number
//  of settle cycles for the gate-delay carry chain, then captures result and flags into an

---
 rtl/alu_issue_seq_if.sv | 28 ++
 rtl/alu_issue_seq.sv | 126 ++++++++++++
 tb/tb_alu_issue_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if
//   Request/response handshake bundle for alu_issue_seq.
//   Request side : in_valid, in_ready, in_op, in_a, in_b
//   Response side: out_valid, out_ready, out_result, out_flags ({N,Z,C,V})
//   slave  = the sequencer's view, master = the requester/consumer's view.
interface alu_issue_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Issues one operation at a time to an external combinational ripple-carry
//   ALU, waits SETTLE_CYCLES clocks for the carry chain to settle, then
//   captures result and flags and offers them downstream. Keeps a sticky
//   overflow flag.
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   bus (slave)                  request/response handshake, see alu_issue_seq_if
//   alu_a, alu_b, alu_ctrl       registered operands/op driven to the ALU
//   alu_out, alu_carry, alu_zero,
//   alu_ovf, alu_neg             ALU result and raw flags
//   ovf_sticky, sticky_clr       sticky overflow and its synchronous clear
//   busy                         high while an operation is settling or held
//
// state  | meaning
// IDLE   | no operation in flight, ready for a request
// SETTLE | operands launched, counting down settle time
// DONE   | result captured and offered downstream
module alu_issue_seq #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_seq_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_neg,
  output logic             ovf_sticky,
  input  logic             sticky_clr,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             accept;
  logic             capture;
  logic             arith;
  logic [3:0]       cap_flags;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [3:0]       out_flags_q;

  // Only ADD (00) and SUB (10) produce meaningful carry/overflow.
  assign arith     = ~alu_ctrl[0];
  assign cap_flags = {alu_neg, alu_zero, arith & alu_carry, arith & alu_ovf};

  always_comb begin
    state_nxt   = state;
    bus.in_ready = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Result consumption and a new accept may share one edge.
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) state_nxt = bus.in_valid ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = bus.in_valid & bus.in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 2'b00;
      cnt      <= 4'd0;
    end else if (accept) begin
      alu_a    <= bus.in_a;
      alu_b    <= bus.in_b;
      alu_ctrl <= bus.in_op;
      cnt      <= 4'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= 4'b0000;
      ovf_sticky   <= 1'b0;
    end else begin
      if (capture) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_out;
        out_flags_q  <= cap_flags;
      end else if (state == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A new overflow wins over a coincident clear.
      if (capture && cap_flags[0]) ovf_sticky <= 1'b1;
      else if (sticky_clr)         ovf_sticky <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_seq.sv
module tb_alu_issue_seq;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sticky_clr = 1'b0;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.WIDTH(W)) bus  ();
  alu_issue_seq_if #(.WIDTH(W)) bus1 ();

  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_ctrl;
  logic         alu_carry, alu_zero, alu_ovf, alu_neg, ovf_sticky, busy;
  logic [W-1:0] alu_a1, alu_b1, alu_out1;
  logic [1:0]   alu_ctrl1;
  logic         alu_carry1, alu_zero1, alu_ovf1, alu_neg1, ovf_sticky1, busy1;

  alu_issue_seq #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr), .busy(busy)
  );

  alu_issue_seq #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1), .alu_out(alu_out1),
    .alu_carry(alu_carry1), .alu_zero(alu_zero1), .alu_ovf(alu_ovf1), .alu_neg(alu_neg1),
    .ovf_sticky(ovf_sticky1), .sticky_clr(sticky_clr), .busy(busy1)
  );

  // Behavioural ripple-carry ALU: returns {neg, zero, carry, ovf, result}.
  // Carry/overflow are don't-care for XOR and SLT; they are driven high there
  // so the sequencer's masking is actually exercised.
  function automatic logic [W+3:0] alu_model(input logic [1:0] op,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c, v;
    case (op)
      2'b00: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[W-1:0]; c = sum[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10: begin
        r = a - b; c = (a < b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin r = a ^ b; c = 1'b1; v = 1'b1; end
      default: begin r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))}; c = 1'b1; v = 1'b1; end
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  always_comb {alu_neg, alu_zero, alu_carry, alu_ovf, alu_out} = alu_model(alu_ctrl, alu_a, alu_b);
  always_comb {alu_neg1, alu_zero1, alu_carry1, alu_ovf1, alu_out1} = alu_model(alu_ctrl1, alu_a1, alu_b1);

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  logic         seen = 1'b0;
  logic [W-1:0] last_res;
  logic [3:0]   last_flags;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expectation pushed on each observed accept, compared when the
  // result first appears, popped when the result is consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else if (!seen) begin
          check("result",  bus.out_result, sb[0].res);
          check("flags",   bus.out_flags,  sb[0].flags);
          check("latency", cyc - sb[0].cyc, S + 1);
          last_res   = bus.out_result;
          last_flags = bus.out_flags;
          seen = 1'b1;
        end
        if (bus.out_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          seen = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [W+3:0] m;
        exp_t e;
        m = alu_model(bus.in_op, bus.in_a, bus.in_b);
        e.res = m[W-1:0];
        e.flags = {m[W+3], m[W+2], m[W+1] & ~bus.in_op[0], m[W] & ~bus.in_op[0]};
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic rdy;
    int n;
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.out_valid || sb.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_op = 2'b00; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b1;
    #23;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_sticky",    ovf_sticky, 0);
    check("rst_alu_ctrl",  alu_ctrl, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    send(2'b00, 32'd5, 32'd3);
    wait_idle();
    check("add_result", last_res, 32'd8);
    check("add_flags",  last_flags, 4'b0000);

    send(2'b10, 32'd3, 32'd5);
    wait_idle();
    check("sub_neg_result", last_res, 32'hFFFF_FFFE);
    check("sub_neg_flags",  last_flags, 4'b1010);

    send(2'b10, 32'd7, 32'd7);
    wait_idle();
    check("sub_zero_result", last_res, 32'd0);
    check("sub_zero_flags",  last_flags, 4'b0100);

    send(2'b00, 32'h7FFF_FFFF, 32'd1);
    wait_idle();
    check("ovf_result", last_res, 32'h8000_0000);
    check("ovf_flags",  last_flags, 4'b1001);
    check("sticky_set", ovf_sticky, 1);
    sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    check("sticky_clr", ovf_sticky, 0);

    // Clear asserted exactly on the capture edge of a new overflow.
    send(2'b00, 32'h7FFF_FFFF, 32'd1);
    repeat (S - 1) @(posedge clk);
    #1; sticky_clr = 1'b1;
    @(posedge clk); #1; sticky_clr = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1);
    wait_idle();

    // Downstream stall in DONE, then back-to-back accept.
    bus.out_ready = 1'b0;
    send(2'b01, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_result",    bus.out_result, 32'h5A5A_5A5A);
      check("stall_flags",     bus.out_flags, 4'b0000);
      check("stall_alu_a",     alu_a, 32'hA5A5_A5A5);
      check("stall_alu_b",     alu_b, 32'hFFFF_FFFF);
      check("stall_in_ready",  bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(2'b11, 32'd3, 32'd5);
    check("b2b_out_valid_fell", bus.out_valid, 0);
    wait_idle();
    check("slt_lt_result", last_res, 32'd1);
    check("slt_lt_flags",  last_flags, 4'b0000);

    send(2'b11, 32'd5, 32'd3);
    wait_idle();
    check("slt_ge_result", last_res, 32'd0);
    check("slt_ge_flags",  last_flags, 4'b0100);

    // Reset while an operation is settling.
    send(2'b00, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    seen = 1'b0;
    check("midrst_busy",      busy, 0);
    check("midrst_alu_a",     alu_a, 0);
    check("midrst_alu_b",     alu_b, 0);
    check("midrst_alu_ctrl",  alu_ctrl, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result",    bus.out_result, 0);
    check("midrst_flags",     bus.out_flags, 0);
    check("midrst_sticky",    ovf_sticky, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_no_valid", bus.out_valid, 0);
    end

    // SETTLE_CYCLES=1 instance: capture on the first clock after accept.
    @(posedge clk); #1;
    bus1.in_op = 2'b00; bus1.in_a = 32'd10; bus1.in_b = 32'd20; bus1.in_valid = 1'b1;
    @(negedge clk);
    check("s1_in_ready", bus1.in_ready, 1);
    @(posedge clk); #1; bus1.in_valid = 1'b0;
    check("s1_busy_after_accept",  busy1, 1);
    check("s1_no_valid_yet",       bus1.out_valid, 0);
    @(posedge clk); #1;
    check("s1_out_valid", bus1.out_valid, 1);
    check("s1_result",    bus1.out_result, 32'd30);
    @(posedge clk); #1;
    check("s1_consumed",  bus1.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
